// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel switch debouncer with a round-robin press/release event stream
module debounce_bank #(
  parameter int NCH    = 4,
  parameter int DIV    = 50000,
  parameter int STABLE = 8,
  parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  sw,
  output logic [NCH-1:0]  db_level,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [CH_W-1:0] ev_ch,
  output logic            ev_rise,
  output logic [NCH-1:0]  overrun,
  input  logic            clr_overrun
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int PW = $clog2(DIV);

  logic [NCH-1:0]  sync1;
  logic [NCH-1:0]  s;
  logic [PW-1:0]   pcnt;
  logic            strobe;
  logic [CW-1:0]   cnt [NCH];
  logic [NCH-1:0]  pend;
  logic [NCH-1:0]  ptype;
  logic [NCH-1:0]  edge_ev;
  logic [NCH-1:0]  take_vec;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] gch;
  logic            gnt;
  logic            out_free;
  int              idx;

  assign strobe   = (pcnt == PW'(DIV - 1));
  assign out_free = !ev_valid || ev_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      s     <= '0;
      pcnt  <= '0;
    end else begin
      sync1 <= sw;
      s     <= sync1;
      pcnt  <= strobe ? '0 : pcnt + PW'(1);
    end
  end

  // A channel's level flips on the strobe that completes STABLE disagreeing samples.
  always_comb begin
    edge_ev = '0;
    for (int i = 0; i < NCH; i++)
      edge_ev[i] = strobe && (s[i] != db_level[i]) && (int'(cnt[i]) + 1 == STABLE);
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    gnt      = 1'b0;
    gch      = '0;
    idx      = 0;
    take_vec = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(ptr) + k) % NCH;
      if (!gnt && pend[idx]) begin
        gnt = 1'b1;
        gch = CH_W'(idx);
      end
    end
    for (int i = 0; i < NCH; i++)
      take_vec[i] = out_free && gnt && (gch == CH_W'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_level <= '0;
      pend     <= '0;
      ptype    <= '0;
      overrun  <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      if (clr_overrun) overrun <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (strobe) begin
          if (s[i] == db_level[i]) begin
            cnt[i] <= '0;
          end else if (edge_ev[i]) begin
            db_level[i] <= s[i];
            cnt[i]      <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
        // A new edge on a slot that is not being drained this cycle loses the old event.
        if (edge_ev[i]) begin
          pend[i]  <= 1'b1;
          ptype[i] <= s[i];
          if (pend[i] && !take_vec[i]) overrun[i] <= 1'b1;
        end else if (take_vec[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ev_valid <= 1'b0;
      ev_ch    <= '0;
      ev_rise  <= 1'b0;
      ptr      <= CH_W'(NCH - 1);
    end else if (out_free) begin
      if (gnt) begin
        ev_valid <= 1'b1;
        ev_ch    <= gch;
        ev_rise  <= ptype[gch];
        ptr      <= gch;
      end else begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule
